// File: rtl/controle_botoes.sv
// controle_botoes: push-button front-end and run-control FSM for the stopwatch.
// Each raw button is normalised to pressed=1, then passed through a 2-flop
// synchronizer and a debounce counter. A press-edge pulse is taken when a
// debounced level is accepted, and the pulses drive the run-state FSM.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   botao0..3     raw buttons: iniciar, pausar, zerar, volta
//   estado        run state: 00 ZERADO, 01 CONTANDO, 10 PAUSADO, 11 VOLTA
//   evento_zera   one-cycle pulse when a zerar press is accepted
//   botoes_limpos debounced levels, active-high pressed, bit i = botao i
module controle_botoes #(
  parameter int unsigned DEB_CICLOS  = 500000,
  parameter bit          ATIVO_BAIXO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       botao0,
  input  logic       botao1,
  input  logic       botao2,
  input  logic       botao3,
  output logic [1:0] estado,
  output logic       evento_zera,
  output logic [3:0] botoes_limpos
);

  localparam int unsigned NB = 4;
  localparam int unsigned CW = $clog2(DEB_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CICLOS - 1);

  typedef enum logic [1:0] {
    ZERADO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    VOLTA    = 2'b11
  } estado_t;

  logic [NB-1:0] bruto;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] pulso;
  logic [CW-1:0] cnt [NB];

  estado_t est_q;
  estado_t est_d;
  logic    zera_d;

  // Normalise polarity so that pressed reads 1 from here on.
  assign bruto = {botao3, botao2, botao1, botao0} ^ {NB{ATIVO_BAIXO}};

  // Synchronizer, debounce and press-edge detection.
  // The press pulse is registered on the acceptance edge, so the FSM acts one
  // edge later, the same cycle that botoes_limpos shows the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= '0;
      sync2         <= '0;
      botoes_limpos <= '0;
      pulso         <= '0;
      for (int i = 0; i < int'(NB); i++) cnt[i] <= '0;
    end else begin
      sync1 <= bruto;
      sync2 <= sync1;
      for (int i = 0; i < int'(NB); i++) begin
        pulso[i] <= 1'b0;
        if (sync2[i] != botoes_limpos[i]) begin
          if (cnt[i] == CNT_MAX) begin
            botoes_limpos[i] <= sync2[i];
            cnt[i]           <= '0;
            pulso[i]         <= sync2[i];  // only 0->1 acceptances are events
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est_q       <= ZERADO;
      evento_zera <= 1'b0;
    end else begin
      est_q       <= est_d;
      evento_zera <= zera_d;
    end
  end

  // Next state: only the highest-priority event in a cycle is considered,
  // even if the state ignores it (lower ones are dropped, not queued).
  always_comb begin
    est_d  = est_q;
    zera_d = 1'b0;
    if (pulso[2]) begin
      est_d  = ZERADO;
      zera_d = 1'b1;
    end else if (pulso[1]) begin
      if (est_q == CONTANDO || est_q == VOLTA) est_d = PAUSADO;
    end else if (pulso[0]) begin
      if (est_q != CONTANDO) est_d = CONTANDO;
    end else if (pulso[3]) begin
      case (est_q)
        CONTANDO: est_d = VOLTA;
        VOLTA:    est_d = CONTANDO;
        default:  est_d = est_q;
      endcase
    end
  end

  assign estado = est_q;

endmodule

// File: tb/tb_controle_botoes.sv
// tb_controle_botoes: directed bench for controle_botoes with DEB_CICLOS=4 and
// active-low raw buttons. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_controle_botoes;

  logic       clk;
  logic       rst;
  logic [3:0] raw;
  logic [1:0] estado;
  logic       evento_zera;
  logic [3:0] botoes_limpos;

  int tests;
  int fails;
  int ez_count;
  int ez_bad;

  controle_botoes #(.DEB_CICLOS(4), .ATIVO_BAIXO(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .botao0       (raw[0]),
    .botao1       (raw[1]),
    .botao2       (raw[2]),
    .botao3       (raw[3]),
    .estado       (estado),
    .evento_zera  (evento_zera),
    .botoes_limpos(botoes_limpos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n cycles, tallying evento_zera pulses and pulses seen outside ZERADO.
  task automatic step_mon(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (evento_zera === 1'b1) begin
        ez_count++;
        if (estado !== 2'b00) ez_bad++;
      end
    end
  endtask

  // Press button b (active low) for 10 cycles, release for 10 cycles.
  task automatic press(input int b, input logic [1:0] exp_est, input int exp_ez, input string tag);
    ez_count = 0;
    ez_bad   = 0;
    raw[b]   = 1'b0;
    step_mon(10);
    chk({tag, "_estado"}, 8'(estado), 8'(exp_est));
    raw[b] = 1'b1;
    step_mon(10);
    chk({tag, "_after_release"}, 8'(estado), 8'(exp_est));
    chk({tag, "_ez_count"}, 8'(ez_count), 8'(exp_ez));
    chk({tag, "_ez_coinc"}, 8'(ez_bad), 8'(0));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    raw   = 4'hF;
    rst   = 1'b1;
    step(3);
    chk("rst_estado", 8'(estado), 8'h00);
    chk("rst_ez", 8'(evento_zera), 8'h00);
    chk("rst_limpos", 8'(botoes_limpos), 8'h00);
    rst = 1'b0;

    // Idle with all buttons released.
    ez_count = 0;
    ez_bad   = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (estado !== 2'b00 || botoes_limpos !== 4'h0) ez_bad++;
      if (evento_zera !== 1'b0) ez_count++;
    end
    chk("idle_state", 8'(ez_bad), 8'h00);
    chk("idle_ez", 8'(ez_count), 8'h00);

    // Start latency: first seen at E0, limpos after E0+5, estado after E0+6.
    raw[0] = 1'b0;
    step(5);
    chk("lat_e4_limpos", 8'(botoes_limpos), 8'h00);
    chk("lat_e4_estado", 8'(estado), 8'h00);
    step(1);
    chk("lat_e5_limpos", 8'(botoes_limpos), 8'h01);
    chk("lat_e5_estado", 8'(estado), 8'h00);
    step(1);
    chk("lat_e6_estado", 8'(estado), 8'h01);
    ez_bad = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (estado !== 2'b01 || botoes_limpos !== 4'h1) ez_bad++;
    end
    chk("hold_stable", 8'(ez_bad), 8'h00);
    raw[0] = 1'b1;
    step(10);
    chk("release_limpos", 8'(botoes_limpos), 8'h00);
    chk("release_estado", 8'(estado), 8'h01);

    // Bounce rejection on pausar: 3-cycle lows never reach acceptance.
    ez_bad = 0;
    for (int r = 0; r < 10; r++) begin
      raw[1] = 1'b0; step(3);
      raw[1] = 1'b1; step(2);
      raw[1] = 1'b0; step(3);
      raw[1] = 1'b1; step(2);
      if (botoes_limpos[1] !== 1'b0) ez_bad++;
    end
    step(6);
    chk("bounce_limpos", 8'(ez_bad), 8'h00);
    chk("bounce_estado", 8'(estado), 8'h01);
    press(1, 2'b10, 0, "bounce_hold");

    // Full sequence from PAUSADO.
    press(0, 2'b01, 0, "seq_iniciar");
    press(3, 2'b11, 0, "seq_volta1");
    press(3, 2'b01, 0, "seq_volta2");
    press(1, 2'b10, 0, "seq_pausar");
    press(0, 2'b01, 0, "seq_iniciar2");
    press(2, 2'b00, 1, "seq_zerar");
    press(2, 2'b00, 1, "zerar_in_zerado");

    // Simultaneity: zerar wins; pausar in ZERADO is ignored.
    press(0, 2'b01, 0, "sim_iniciar");
    ez_count = 0;
    ez_bad   = 0;
    raw      = 4'h0;
    step_mon(10);
    chk("sim_all_estado", 8'(estado), 8'h00);
    raw = 4'hF;
    step_mon(10);
    chk("sim_all_ez", 8'(ez_count), 8'h01);
    chk("sim_all_coinc", 8'(ez_bad), 8'h00);
    press(1, 2'b00, 0, "sim_pausar_zerado");

    // Asynchronous reset mid-operation with zerar mid-debounce.
    press(0, 2'b01, 0, "ar_iniciar");
    press(3, 2'b11, 0, "ar_volta");
    raw[2] = 1'b0;
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_estado_async", 8'(estado), 8'h00);
    chk("ar_ez_async", 8'(evento_zera), 8'h00);
    chk("ar_limpos_async", 8'(botoes_limpos), 8'h00);
    raw[2] = 1'b1;
    step(2);
    rst = 1'b0;
    ez_count = 0;
    ez_bad   = 0;
    step_mon(20);
    chk("ar_post_ez", 8'(ez_count), 8'h00);
    chk("ar_post_estado", 8'(estado), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
